// File: rtl/vx_mem_perf_monitor.sv
// Multi-port LSU memory profiler: lane read/write/response counts, outstanding reads, latency and peak.
// Define MEM_PERF_PER_PORT_EN to add per-port pending/latency outputs.
`timescale 1ns/1ps
module vx_mem_perf_monitor #(
    parameter int NUM_PORTS = 4,
    parameter int NUM_LANES = 4,
    parameter int CTR_BITS  = 44,
    parameter int PEND_BITS = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic [NUM_PORTS-1:0]           req_valid,
    input  logic [NUM_PORTS-1:0]           req_ready,
    input  logic [NUM_PORTS-1:0]           req_rw,
    input  logic [NUM_PORTS*NUM_LANES-1:0] req_mask,
    input  logic [NUM_PORTS-1:0]           rsp_valid,
    input  logic [NUM_PORTS-1:0]           rsp_ready,
    input  logic [NUM_PORTS*NUM_LANES-1:0] rsp_mask,
    output logic [CTR_BITS-1:0]            perf_reads,
    output logic [CTR_BITS-1:0]            perf_writes,
    output logic [CTR_BITS-1:0]            perf_rsps,
    output logic [CTR_BITS-1:0]            perf_latency,
    output logic [PEND_BITS-1:0]           pending,
    output logic [PEND_BITS-1:0]           pending_max,
    output logic                           underflow
`ifdef MEM_PERF_PER_PORT_EN
    ,
    output logic [NUM_PORTS*PEND_BITS-1:0] port_pending,
    output logic [NUM_PORTS*CTR_BITS-1:0]  port_latency
`endif
);

    localparam int CNT_W      = $clog2(NUM_PORTS*NUM_LANES+1);
    localparam int PORT_CNT_W = $clog2(NUM_LANES+1);
    localparam int PW         = PEND_BITS + 2;
    localparam int AW         = ((CTR_BITS > PEND_BITS) ? CTR_BITS : PEND_BITS) + 1;
    localparam int SW         = AW + 1;
    localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
    localparam logic [PEND_BITS-1:0] PEND_MAX = '1;

    function automatic logic [CTR_BITS-1:0] sat_add(input logic [CTR_BITS-1:0] acc,
                                                    input logic [AW-1:0]       inc);
        logic [SW-1:0] s;
        s = SW'(acc) + SW'(inc);
        return (s > SW'(CTR_MAX)) ? CTR_MAX : s[CTR_BITS-1:0];
    endfunction

    function automatic logic pend_uflow(input logic [PEND_BITS-1:0] cur,
                                        input logic [PW-1:0]        add,
                                        input logic [PW-1:0]        sub);
        return (PW'(cur) + add) < sub;
    endfunction

    // Responses beyond what is outstanding clamp to zero; growth clamps at all-ones.
    function automatic logic [PEND_BITS-1:0] pend_next(input logic [PEND_BITS-1:0] cur,
                                                       input logic [PW-1:0]        add,
                                                       input logic [PW-1:0]        sub);
        logic [PW-1:0] total;
        total = PW'(cur) + add;
        if (total < sub) return '0;
        total = total - sub;
        return (total > PW'(PEND_MAX)) ? PEND_MAX : total[PEND_BITS-1:0];
    endfunction

    logic [CNT_W-1:0]     rd_cnt, wr_cnt, rsp_cnt;
    logic [CNT_W-1:0]     rd_cnt_q, wr_cnt_q;
    logic [CTR_BITS-1:0]  reads_q, reads_d, writes_q, writes_d;
    logic [CTR_BITS-1:0]  rsps_q, rsps_d, latency_q, latency_d;
    logic [PEND_BITS-1:0] pending_q, pending_d, pending_max_q, pending_max_d;
    logic                 underflow_q, underflow_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        rd_cnt  = '0;
        wr_cnt  = '0;
        rsp_cnt = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (req_valid[p] && req_ready[p] && req_mask[p*NUM_LANES+l]) begin
                    if (req_rw[p]) wr_cnt = wr_cnt + CNT_W'(1);
                    else           rd_cnt = rd_cnt + CNT_W'(1);
                end
                if (rsp_valid[p] && rsp_ready[p] && rsp_mask[p*NUM_LANES+l])
                    rsp_cnt = rsp_cnt + CNT_W'(1);
            end
        end
    end

    // Requests are delayed one cycle so a response never retires a read issued in the same cycle.
    always_comb begin
        pending_d     = pend_next(pending_q, PW'(rd_cnt_q), PW'(rsp_cnt));
        underflow_d   = underflow_q | pend_uflow(pending_q, PW'(rd_cnt_q), PW'(rsp_cnt));
        pending_max_d = (clear || (pending_d > pending_max_q)) ? pending_d : pending_max_q;
        reads_d       = clear ? '0 : sat_add(reads_q,   AW'(rd_cnt_q));
        writes_d      = clear ? '0 : sat_add(writes_q,  AW'(wr_cnt_q));
        rsps_d        = clear ? '0 : sat_add(rsps_q,    AW'(rsp_cnt));
        latency_d     = clear ? '0 : sat_add(latency_q, AW'(pending_q));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            reads_q       <= '0;
            writes_q      <= '0;
            rsps_q        <= '0;
            latency_q     <= '0;
            pending_q     <= '0;
            pending_max_q <= '0;
            underflow_q   <= 1'b0;
        end else begin
            rd_cnt_q      <= rd_cnt;
            wr_cnt_q      <= wr_cnt;
            reads_q       <= reads_d;
            writes_q      <= writes_d;
            rsps_q        <= rsps_d;
            latency_q     <= latency_d;
            pending_q     <= pending_d;
            pending_max_q <= pending_max_d;
            underflow_q   <= underflow_d;
        end
    end

    assign perf_reads   = reads_q;
    assign perf_writes  = writes_q;
    assign perf_rsps    = rsps_q;
    assign perf_latency = latency_q;
    assign pending      = pending_q;
    assign pending_max  = pending_max_q;
    assign underflow    = underflow_q;

`ifdef MEM_PERF_PER_PORT_EN
    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
        logic [PORT_CNT_W-1:0] rd_c, rsp_c, rd_c_q;
        logic [PEND_BITS-1:0]  pend_q, pend_d;
        logic [CTR_BITS-1:0]   lat_q, lat_d;

        always_comb begin
            rd_c  = '0;
            rsp_c = '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                if (req_valid[gp] && req_ready[gp] && !req_rw[gp] && req_mask[gp*NUM_LANES+l])
                    rd_c = rd_c + PORT_CNT_W'(1);
                if (rsp_valid[gp] && rsp_ready[gp] && rsp_mask[gp*NUM_LANES+l])
                    rsp_c = rsp_c + PORT_CNT_W'(1);
            end
        end

        always_comb begin
            pend_d = pend_next(pend_q, PW'(rd_c_q), PW'(rsp_c));
            lat_d  = clear ? '0 : sat_add(lat_q, AW'(pend_q));
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                rd_c_q <= '0;
                pend_q <= '0;
                lat_q  <= '0;
            end else begin
                rd_c_q <= rd_c;
                pend_q <= pend_d;
                lat_q  <= lat_d;
            end
        end

        assign port_pending[gp*PEND_BITS +: PEND_BITS] = pend_q;
        assign port_latency[gp*CTR_BITS +: CTR_BITS]   = lat_q;
    end
`endif

endmodule

// File: tb/tb_vx_mem_perf_monitor.sv
// Scoreboarded bench for vx_mem_perf_monitor: a default instance plus an 8-bit-counter instance on shared stimulus.
// Honours MEM_PERF_PER_PORT_EN for the per-port outputs.
`timescale 1ns/1ps
module tb_vx_mem_perf_monitor;

    localparam int NP = 4;
    localparam int NL = 4;
    localparam int CB = 44;
    localparam int PB = 16;
    localparam int SB = 8;

    logic clk = 1'b0;
    logic reset, clear;
    logic [NP-1:0]    req_valid, req_ready, req_rw, rsp_valid, rsp_ready;
    logic [NP*NL-1:0] req_mask, rsp_mask;

    logic [CB-1:0] perf_reads, perf_writes, perf_rsps, perf_latency;
    logic [PB-1:0] pending, pending_max;
    logic          underflow;
    logic [SB-1:0] s_reads, s_writes, s_rsps, s_latency;
    logic [PB-1:0] s_pending, s_pending_max;
    logic          s_underflow;
`ifdef MEM_PERF_PER_PORT_EN
    logic [NP*PB-1:0] port_pending, s_port_pending;
    logic [NP*CB-1:0] port_latency;
    logic [NP*SB-1:0] s_port_latency;
`endif

    vx_mem_perf_monitor #(.NUM_PORTS(NP), .NUM_LANES(NL), .CTR_BITS(CB), .PEND_BITS(PB)) u_dut (
        .clk(clk), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask),
        .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_rsps(perf_rsps),
        .perf_latency(perf_latency), .pending(pending), .pending_max(pending_max),
        .underflow(underflow)
`ifdef MEM_PERF_PER_PORT_EN
        , .port_pending(port_pending), .port_latency(port_latency)
`endif
    );

    vx_mem_perf_monitor #(.NUM_PORTS(NP), .NUM_LANES(NL), .CTR_BITS(SB), .PEND_BITS(PB)) u_small (
        .clk(clk), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_mask(rsp_mask),
        .perf_reads(s_reads), .perf_writes(s_writes), .perf_rsps(s_rsps),
        .perf_latency(s_latency), .pending(s_pending), .pending_max(s_pending_max),
        .underflow(s_underflow)
`ifdef MEM_PERF_PER_PORT_EN
        , .port_pending(s_port_pending), .port_latency(s_port_latency)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        longint                reads;
        longint                writes;
        longint                rsps;
        longint                lat;
        int                    pend;
        int                    pmax;
        bit                    uf;
        logic [NP-1:0][31:0]   ppend;
        logic [NP-1:0][63:0]   plat;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: unbounded true totals; saturation is applied when comparing.
    longint m_reads, m_writes, m_rsps, m_lat;
    int     m_pend, m_pmax, m_rd_d1, m_wr_d1;
    bit     m_uf;
    int     m_ppend [NP];
    longint m_plat  [NP];
    int     m_prd_d1[NP];

    function automatic longint sat(input longint v, input int bits);
        longint mx;
        mx = (longint'(1) << bits) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int pop4(input logic [NL-1:0] m);
        int n;
        n = 0;
        for (int i = 0; i < NL; i++) n += int'(m[i]);
        return n;
    endfunction

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_step();
        int   rd_now, wr_now, rsp_now, total, pmax_lim;
        int   prd[NP];
        int   prsp[NP];
        exp_t e;
        rd_now = 0; wr_now = 0; rsp_now = 0;
        pmax_lim = (1 << PB) - 1;
        for (int p = 0; p < NP; p++) begin
            prd[p]  = 0;
            prsp[p] = 0;
            if (req_valid[p] && req_ready[p]) begin
                if (req_rw[p]) wr_now += pop4(req_mask[p*NL +: NL]);
                else           prd[p]  = pop4(req_mask[p*NL +: NL]);
            end
            if (rsp_valid[p] && rsp_ready[p]) prsp[p] = pop4(rsp_mask[p*NL +: NL]);
            rd_now  += prd[p];
            rsp_now += prsp[p];
        end
        if (reset) begin
            m_reads = 0; m_writes = 0; m_rsps = 0; m_lat = 0;
            m_pend = 0; m_pmax = 0; m_uf = 0; m_rd_d1 = 0; m_wr_d1 = 0;
            for (int p = 0; p < NP; p++) begin
                m_ppend[p] = 0; m_plat[p] = 0; m_prd_d1[p] = 0;
            end
        end else begin
            m_lat    = clear ? 0 : m_lat + m_pend;
            m_reads  = clear ? 0 : m_reads + m_rd_d1;
            m_writes = clear ? 0 : m_writes + m_wr_d1;
            m_rsps   = clear ? 0 : m_rsps + rsp_now;
            total = m_pend + m_rd_d1;
            if (rsp_now > total) begin
                m_pend = 0;
                m_uf   = 1;
            end else begin
                m_pend = (total - rsp_now > pmax_lim) ? pmax_lim : total - rsp_now;
            end
            m_pmax  = (clear || m_pend > m_pmax) ? m_pend : m_pmax;
            m_rd_d1 = rd_now;
            m_wr_d1 = wr_now;
            for (int p = 0; p < NP; p++) begin
                m_plat[p] = clear ? 0 : m_plat[p] + m_ppend[p];
                total = m_ppend[p] + m_prd_d1[p];
                if (prsp[p] > total) m_ppend[p] = 0;
                else m_ppend[p] = (total - prsp[p] > pmax_lim) ? pmax_lim : total - prsp[p];
                m_prd_d1[p] = prd[p];
            end
        end
        e.reads = m_reads; e.writes = m_writes; e.rsps = m_rsps; e.lat = m_lat;
        e.pend = m_pend; e.pmax = m_pmax; e.uf = m_uf;
        for (int p = 0; p < NP; p++) begin
            e.ppend[p] = 32'(m_ppend[p]);
            e.plat[p]  = 64'(m_plat[p]);
        end
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic rst, input logic clr,
                         input logic [NP-1:0] rv, input logic [NP-1:0] rr, input logic [NP-1:0] rw,
                         input logic [NP*NL-1:0] rm,
                         input logic [NP-1:0] sv, input logic [NP-1:0] sr, input logic [NP*NL-1:0] sm);
        @(negedge clk);
        reset = rst; clear = clr;
        req_valid = rv; req_ready = rr; req_rw = rw; req_mask = rm;
        rsp_valid = sv; rsp_ready = sr; rsp_mask = sm;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) issue(1'b1, 1'b0, '0, '0, '0, '0, '0, '0, '0);
    endtask

    // Monitor: the outputs after every active edge are compared with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("perf_reads",     perf_reads,   sat(e.reads, CB));
                check("perf_writes",    perf_writes,  sat(e.writes, CB));
                check("perf_rsps",      perf_rsps,    sat(e.rsps, CB));
                check("perf_latency",   perf_latency, sat(e.lat, CB));
                check("pending",        pending,      e.pend);
                check("pending_max",    pending_max,  e.pmax);
                check("underflow",      underflow,    e.uf);
                check("sat8_reads",     s_reads,      sat(e.reads, SB));
                check("sat8_writes",    s_writes,     sat(e.writes, SB));
                check("sat8_rsps",      s_rsps,       sat(e.rsps, SB));
                check("sat8_latency",   s_latency,    sat(e.lat, SB));
                check("sat8_pending",   s_pending,    e.pend);
`ifdef MEM_PERF_PER_PORT_EN
                for (int p = 0; p < NP; p++) begin
                    check($sformatf("port_pending[%0d]", p), port_pending[p*PB +: PB], e.ppend[p]);
                    check($sformatf("port_latency[%0d]", p), port_latency[p*CB +: CB],
                          sat(longint'(e.plat[p]), CB));
                    check($sformatf("sat8_port_latency[%0d]", p), s_port_latency[p*SB +: SB],
                          sat(longint'(e.plat[p]), SB));
                end
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NP-1:0]    rv, rr, rw, sv, sr;
        logic [NP*NL-1:0] rm, sm;
        int               avail;
        reset = 1'b1; clear = 1'b0;
        req_valid = '0; req_ready = '0; req_rw = '0; req_mask = '0;
        rsp_valid = '0; rsp_ready = '0; rsp_mask = '0;
        do_reset(3);

        // Port 0 reads four lanes, later all four respond.
        issue(1'b0, 1'b0, 4'b0001, 4'hf, 4'b0000, 16'h000f, '0, '0, '0);
        idle(4);
        issue(1'b0, 1'b0, '0, '0, '0, '0, 4'b0001, 4'hf, 16'h000f);
        idle(3);

        // All four ports write two lanes in one cycle.
        issue(1'b0, 1'b0, 4'hf, 4'hf, 4'hf, 16'h3333, '0, '0, '0);
        idle(3);

        // Response with nothing outstanding sets the sticky underflow flag.
        issue(1'b0, 1'b0, '0, '0, '0, '0, 4'b0001, 4'hf, 16'h0001);
        idle(4);
        do_reset(1);

        // Clear while a one-lane read fires; outstanding reads keep being tracked.
        issue(1'b0, 1'b0, 4'b0001, 4'hf, 4'b0000, 16'h0007, '0, '0, '0);
        idle(2);
        issue(1'b0, 1'b1, 4'b0010, 4'hf, 4'b0000, 16'h0010, '0, '0, '0);
        idle(2);
        issue(1'b0, 1'b0, '0, '0, '0, '0, 4'b0011, 4'hf, 16'h0017);
        idle(3);

        // Sixteen reads held outstanding long enough to saturate the 8-bit latency counter.
        do_reset(1);
        issue(1'b0, 1'b0, 4'hf, 4'hf, 4'h0, 16'hffff, '0, '0, '0);
        idle(22);
        issue(1'b0, 1'b0, '0, '0, '0, '0, 4'hf, 4'hf, 16'hffff);
        idle(2);

        // Port 2 reads two lanes, port 3 reads one lane.
        do_reset(1);
        issue(1'b0, 1'b0, 4'b1100, 4'hf, 4'h0, 16'h1300, '0, '0, '0);
        idle(3);

        // Random traffic whose responses never exceed what each port has outstanding.
        do_reset(1);
        for (int c = 0; c < 300; c++) begin
            rv = NP'($urandom); rr = NP'($urandom); rw = NP'($urandom); rm = (NP*NL)'($urandom);
            sv = NP'($urandom); sr = NP'($urandom); sm = (NP*NL)'($urandom);
            for (int p = 0; p < NP; p++) begin
                avail = m_ppend[p] + m_prd_d1[p];
                if (pop4(sm[p*NL +: NL]) > avail) sm[p*NL +: NL] = '0;
            end
            issue(1'b0, ($urandom_range(31) == 0), rv, rr, rw, rm, sv, sr, sm);
        end

        // Unconstrained random traffic with occasional resets and clears.
        for (int c = 0; c < 300; c++) begin
            rv = NP'($urandom); rr = NP'($urandom); rw = NP'($urandom); rm = (NP*NL)'($urandom);
            sv = NP'($urandom); sr = NP'($urandom); sm = (NP*NL)'($urandom);
            issue(($urandom_range(99) == 0), ($urandom_range(31) == 0), rv, rr, rw, rm, sv, sr, sm);
        end
        idle(2);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
